pwm_peripheral: RTL and testbench

Consumes the configuration registers written over SPI (output enables, PWM-mode enables, duty cycle) and drives 16 output pins. Each pin is forced low, forced high, or driven by one shared 8-bit PWM waveform. Sits directly downstream of the SPI register block; its outputs feed the top-level `uo_out`/`uio_out` pins.

---
 rtl/pwm_peripheral_if.sv | 31 +++
 rtl/pwm_peripheral.sv | 83 ++++++++
 tb/tb_pwm_peripheral.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_peripheral_if.sv
// Register-side bundle between the SPI register block and pwm_peripheral.
// master: drives the configuration registers; slave: the PWM peripheral.
interface pwm_peripheral_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_strobe;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_strobe
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_strobe
    );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-pin output driver: each pin is forced low, forced high, or follows one
// shared 8-bit PWM waveform. CLK_DIV clk cycles per PWM counter step.
// Optional macro PWM_DUTY_SHADOW_EN: when defined, the duty value is latched
// only at the 255->0 period wrap (glitch-free duty updates); when undefined
// the duty input is used directly and mid-period changes take effect at once.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic             clk,
    input  logic             rst,
    pwm_peripheral_if.slave  bus
);

    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [7:0]       cnt;
    logic [7:0]       duty_act;
    logic [15:0]      out_q;
    logic             strobe_q;

    logic             tick_c;
    logic             wrap_c;
    logic             pwm_sig_c;
    logic [15:0]      en_out_c;
    logic [15:0]      en_pwm_c;
    logic [15:0]      out_nxt_c;

    // Step/wrap decode, waveform compare and per-pin output selection
    always_comb begin
        tick_c    = (pre == PRE_MAX);
        wrap_c    = tick_c && (cnt == 8'hFF);
        pwm_sig_c = (duty_act == 8'hFF) || (cnt < duty_act);
        en_out_c  = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
        en_pwm_c  = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
        out_nxt_c = en_out_c & (~en_pwm_c | {16{pwm_sig_c}});
    end

    // Prescaler and 8-bit PWM counter; counter advances once per prescaler wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            cnt <= '0;
        end else if (tick_c) begin
            pre <= '0;
            cnt <= cnt + 8'd1;
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

`ifdef PWM_DUTY_SHADOW_EN
    // Shadowed duty: take the new request only on the last step of a period
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_act <= '0;
        end else if (wrap_c) begin
            duty_act <= bus.pwm_duty_cycle;
        end
    end
`else
    // Unshadowed duty: compare directly against the requested value
    always_comb begin
        duty_act = bus.pwm_duty_cycle;
    end
`endif

    // Registered pin drive and start-of-period pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            out_q    <= out_nxt_c;
            strobe_q <= wrap_c;
        end
    end

    assign bus.out           = out_q;
    assign bus.period_strobe = strobe_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: two instances (CLK_DIV=13 and CLK_DIV=1) share
// one stimulus stream and are compared every cycle against a cycle-count
// model, plus directed period measurements and a constant-output table.
module tb_pwm_peripheral;

    localparam int unsigned D0 = 13;
    localparam int unsigned D1 = 1;
    localparam int P0 = 256 * D0;
`ifdef PWM_DUTY_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] eo = '0;
    logic [15:0] ep = '0;
    logic [7:0]  duty = '0;

    pwm_peripheral_if bus0 ();
    pwm_peripheral_if bus1 ();

    assign bus0.en_reg_out_7_0  = eo[7:0];
    assign bus0.en_reg_out_15_8 = eo[15:8];
    assign bus0.en_reg_pwm_7_0  = ep[7:0];
    assign bus0.en_reg_pwm_15_8 = ep[15:8];
    assign bus0.pwm_duty_cycle  = duty;
    assign bus1.en_reg_out_7_0  = eo[7:0];
    assign bus1.en_reg_out_15_8 = eo[15:8];
    assign bus1.en_reg_pwm_7_0  = ep[7:0];
    assign bus1.en_reg_pwm_15_8 = ep[15:8];
    assign bus1.pwm_duty_cycle  = duty;

    pwm_peripheral #(.CLK_DIV(D0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pwm_peripheral #(.CLK_DIV(D1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: state derived from edges elapsed since reset
    int unsigned k = 0;
    bit          m_valid = 1'b0;
    logic [15:0] m_out [2];
    logic        m_str [2];
    logic [7:0]  m_da  [2];
    int unsigned div_of [2] = '{D0, D1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [15:0] s_eo, input logic [15:0] s_ep,
                              input logic [7:0] s_d);
        if (r) begin
            k = 0;
            m_valid = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_out[i] = '0;
                m_str[i] = 1'b0;
                m_da[i]  = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int unsigned dv;
                int unsigned c;
                logic [7:0]  da;
                bit          pwm;
                dv  = div_of[i];
                c   = (k / dv) % 256;
                da  = SHADOW ? m_da[i] : s_d;
                pwm = (da == 8'hFF) || (c < 32'(da));
                m_out[i] = s_eo & (~s_ep | {16{pwm}});
                m_str[i] = ((k + 1) % (256 * dv)) == 0;
                if (m_str[i]) m_da[i] = s_d;
            end
            k++;
        end
    endtask

    // One clock: apply held inputs, advance model, compare both instances
    task automatic step();
        logic        r;
        logic [15:0] s_eo;
        logic [15:0] s_ep;
        logic [7:0]  s_d;
        r = rst; s_eo = eo; s_ep = ep; s_d = duty;
        @(posedge clk);
        #1;
        model_edge(r, s_eo, s_ep, s_d);
        if (m_valid) begin
            check("div13 out/strobe", {15'b0, bus0.period_strobe, bus0.out},
                  {15'b0, m_str[0], m_out[0]});
            check("div1 out/strobe", {15'b0, bus1.period_strobe, bus1.out},
                  {15'b0, m_str[1], m_out[1]});
        end
    endtask

    task automatic wait_strobe(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (bus0.period_strobe !== 1'b1 && n < P0 + 16);
        check(name, {31'b0, bus0.period_strobe}, 32'd1);
    endtask

    // Run n cycles on the CLK_DIV=13 instance and summarise what it drove
    task automatic window(input int n, output int hi, output int nz, output int nf,
                          output int ns, output int first);
        hi = 0; nz = 0; nf = 0; ns = 0; first = -1;
        for (int i = 1; i <= n; i++) begin
            step();
            if (bus0.out[0] === 1'b1) hi++;
            if (bus0.out !== 16'h0000) nz++;
            if (bus0.out === 16'hFFFF) nf++;
            if (bus0.period_strobe === 1'b1) begin
                ns++;
                if (first < 0) first = i;
            end
        end
    endtask

    typedef struct {
        logic [15:0] eo;
        logic [15:0] ep;
        logic [7:0]  duty;
        logic [15:0] exp;
    } vec_t;

    initial begin
        vec_t vt [9];
        int hi, nz, nf, ns, first, hi1;

        vt[0] = '{16'hFFFF, 16'h0000, 8'h80, 16'hFFFF};
        vt[1] = '{16'h00FF, 16'hFF00, 8'h80, 16'h00FF};
        vt[2] = '{16'hF0F0, 16'hF0F0, 8'h00, 16'h0000};
        vt[3] = '{16'hF0F0, 16'hF0F0, 8'hFF, 16'hF0F0};
        vt[4] = '{16'hFFFF, 16'h00FF, 8'h00, 16'hFF00};
        vt[5] = '{16'hFFFF, 16'h00FF, 8'hFF, 16'hFFFF};
        vt[6] = '{16'h0000, 16'hFFFF, 8'hFF, 16'h0000};
        vt[7] = '{16'hA5A5, 16'h0F0F, 8'h00, 16'hA0A0};
        vt[8] = '{16'h1234, 16'hFFFF, 8'hFF, 16'h1234};

        // Reset state, then all enables off for two periods
        rst = 1'b1; eo = '0; ep = '0; duty = 8'h80;
        repeat (3) step();
        check("reset out", {16'b0, bus0.out}, 32'h0);
        check("reset strobe", {31'b0, bus0.period_strobe}, 32'h0);
        rst = 1'b0;
        window(P0 - 1, hi, nz, nf, ns, first);
        check("no strobe before first wrap", 32'(ns), 32'd0);
        check("disabled out stays 0 (p1)", 32'(nz), 32'd0);
        window(P0, hi, nz, nf, ns, first);
        check("first strobe position", 32'(first), 32'd1);
        check("disabled out stays 0 (p2)", 32'(nz), 32'd0);

        // Forced-high pins, one cycle of latency
        eo = 16'hFFFF; ep = 16'h0000;
        step();
        check("force high latency", {16'b0, bus0.out}, 32'h0000FFFF);
        window(50, hi, nz, nf, ns, first);
        check("force high stable", 32'(nf), 32'd50);

        // 50% duty on pin 0
        eo = 16'h0001; ep = 16'h0001; duty = 8'h80;
        wait_strobe("strobe seen (duty 80)");
        window(P0, hi, nz, nf, ns, first);
        check("duty 80 high time", 32'(hi), 32'd1664);
        check("strobe spacing", 32'(first), 32'(P0));
        check("strobe count per period", 32'(ns), 32'd1);

        // Duty extremes
        duty = 8'h00;
        wait_strobe("strobe seen (duty 00)");
        window(P0, hi, nz, nf, ns, first);
        check("duty 00 high time", 32'(hi), 32'd0);
        duty = 8'hFF;
        wait_strobe("strobe seen (duty FF)");
        window(2 * P0, hi, nz, nf, ns, first);
        check("duty FF high time", 32'(hi), 32'(2 * P0));
        check("duty FF strobes", 32'(ns), 32'd2);

        // Duty change 0x40 -> 0xC0 at cnt = 0x20
        duty = 8'h40;
        wait_strobe("strobe seen (duty 40)");
        window(32 * D0, hi1, nz, nf, ns, first);
        check("pre-change high time", 32'(hi1), 32'(32 * D0));
        duty = 8'hC0;
        window(P0 - 32 * D0, hi, nz, nf, ns, first);
        check("changed period high time", 32'(hi1 + hi), SHADOW ? 32'd832 : 32'd2496);
        check("changed period end strobe", 32'(first), 32'(P0 - 32 * D0));
        window(P0, hi, nz, nf, ns, first);
        check("next period high time", 32'(hi), 32'd2496);

        // One-cycle reset in the middle of a high pulse
        window(100, hi, nz, nf, ns, first);
        check("pin high before reset", {31'b0, bus0.out[0]}, 32'd1);
        rst = 1'b1;
        step();
        check("reset clears out", {16'b0, bus0.out}, 32'h0);
        check("reset clears strobe", {31'b0, bus0.period_strobe}, 32'h0);
        rst = 1'b0;
        window(P0, hi, nz, nf, ns, first);
        check("post-reset first strobe", 32'(first), 32'(P0));
        check("post-reset high time", 32'(hi), SHADOW ? 32'd0 : 32'd2496);

        // Constant-output table on the CLK_DIV=1 instance
        for (int v = 0; v < 9; v++) begin
            eo = vt[v].eo; ep = vt[v].ep; duty = vt[v].duty;
            repeat (520) step();
            check($sformatf("table[%0d] div1 out", v), {16'b0, bus1.out}, {16'b0, vt[v].exp});
        end

        // Random enables, duties and occasional resets against the model
        for (int b = 0; b < 40; b++) begin
            int hold;
            eo = 16'($urandom);
            ep = 16'($urandom);
            case ($urandom_range(0, 3))
                0: duty = 8'h00;
                1: duty = 8'hFF;
                default: duty = 8'($urandom);
            endcase
            rst = ($urandom_range(0, 19) == 0);
            if (rst) begin
                step();
                rst = 1'b0;
            end
            hold = int'($urandom_range(1, 600));
            repeat (hold) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
